// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: Y = A - B, one bit per clock through a single full-adder
// cell fed with ~B and an initial carry of 1. Operands and result use valid/ready.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             START_VALID,
  output logic             START_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             DONE_VALID,
  input  logic             DONE_READY,
  output logic [WIDTH-1:0] Y,
  output logic             BORROW,
  output logic             OVF,
  output logic [1:0]       DBG_STATE
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; START_READY is high only in IDLE, DONE_VALID only in DONE.

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [CW-1:0]    count_q, count_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;

  logic             b_inv;
  logic             diff_bit;
  logic             carry_out;
  logic [WIDTH-1:0] y_shift;

  assign b_inv     = ~b_sr_q[0];
  assign diff_bit  = a_sr_q[0] ^ b_inv ^ carry_q;
  assign carry_out = (a_sr_q[0] & b_inv) | (a_sr_q[0] & carry_q) | (b_inv & carry_q);

  // New difference bit enters at the MSB so bit 0 lands in place after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_y1
      assign y_shift = diff_bit;
    end else begin : g_yn
      assign y_shift = {diff_bit, y_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    y_d      = y_q;
    count_d  = count_q;
    carry_d  = carry_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (START_VALID) begin
          a_sr_d  = A;
          b_sr_d  = B;
          carry_d = 1'b1;
          count_d = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        y_d     = y_shift;
        carry_d = carry_out;
        count_d = count_q + CW'(1);
        // carry_q here is the carry into the MSB
        if (count_q == LAST_BIT) begin
          borrow_d = ~carry_out;
          ovf_d    = carry_q ^ carry_out;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (DONE_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      y_q      <= '0;
      count_q  <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      y_q      <= y_d;
      count_q  <= count_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign START_READY = (state_q == S_IDLE);
  assign DONE_VALID  = (state_q == S_DONE);
  assign Y           = y_q;
  assign BORROW      = borrow_q;
  assign OVF         = ovf_q;
  assign DBG_STATE   = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed vector table, backpressure, operand
// scrambling during RUN, async reset mid-operation, and randomized model checks.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RESET_N = 1'b0;
  logic         START_VALID = 1'b0;
  logic         START_READY;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         DONE_VALID;
  logic         DONE_READY = 1'b0;
  logic [W-1:0] Y;
  logic         BORROW;
  logic         OVF;
  logic [1:0]   DBG_STATE;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
    logic         borrow;
    logic         ovf;
  } vec_t;

  vec_t vecs[6];

  serial_subtractor #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .START_VALID(START_VALID), .START_READY(START_READY),
    .A(A), .B(B),
    .DONE_VALID(DONE_VALID), .DONE_READY(DONE_READY),
    .Y(Y), .BORROW(BORROW), .OVF(OVF),
    .DBG_STATE(DBG_STATE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] y, output logic bo, output logic ov);
    int sa, sb, sd;
    y  = a - b;
    bo = (a < b);
    sa = $signed(a);
    sb = $signed(b);
    sd = sa - sb;
    ov = (sd > (2 ** (W - 1)) - 1) || (sd < -(2 ** (W - 1)));
  endfunction

  task automatic wait_start_ready();
    int n = 0;
    while (!START_READY && n < 40) begin
      @(posedge CLK); #1;
      n++;
    end
    check("start_ready_wait", {31'd0, START_READY}, 32'd1);
  endtask

  // One full transaction; scramble drives junk on inputs while busy.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ey, input logic eb, input logic eo,
                        input bit scramble, input int hold);
    int lat;
    wait_start_ready();
    START_VALID = 1'b1;
    A = a;
    B = b;
    @(posedge CLK); #1;
    START_VALID = 1'b0;
    check("accepted", {31'd0, START_READY}, 32'd0);
    lat = 0;
    while (!DONE_VALID && lat < 50) begin
      if (scramble) begin
        A = W'($urandom);
        B = W'($urandom);
        START_VALID = 1'($urandom_range(0, 1));
        DONE_READY = 1'($urandom_range(0, 1));
      end
      @(posedge CLK); #1;
      lat++;
    end
    START_VALID = 1'b0;
    DONE_READY = 1'b0;
    check("latency", lat, W);
    check("y", {24'd0, Y}, {24'd0, ey});
    check("borrow", {31'd0, BORROW}, {31'd0, eb});
    check("ovf", {31'd0, OVF}, {31'd0, eo});
    for (int i = 0; i < hold; i++) begin
      A = W'($urandom);
      B = W'($urandom);
      START_VALID = 1'($urandom_range(0, 1));
      @(posedge CLK); #1;
      check("hold_done_valid", {31'd0, DONE_VALID}, 32'd1);
      check("hold_start_ready", {31'd0, START_READY}, 32'd0);
      check("hold_y", {24'd0, Y}, {24'd0, ey});
      check("hold_flags", {30'd0, BORROW, OVF}, {30'd0, eb, eo});
    end
    START_VALID = 1'b0;
    DONE_READY = 1'b1;
    @(posedge CLK); #1;
    DONE_READY = 1'b0;
    check("release_done_valid", {31'd0, DONE_VALID}, 32'd0);
    check("release_start_ready", {31'd0, START_READY}, 32'd1);
  endtask

  initial begin
    logic [W-1:0] ra, rb, ey;
    logic         eb, eo;

    vecs[0] = '{a: 8'h05, b: 8'h03, y: 8'h02, borrow: 1'b0, ovf: 1'b0};
    vecs[1] = '{a: 8'h03, b: 8'h05, y: 8'hFE, borrow: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 8'h80, b: 8'h01, y: 8'h7F, borrow: 1'b0, ovf: 1'b1};
    vecs[3] = '{a: 8'h7F, b: 8'hFF, y: 8'h80, borrow: 1'b1, ovf: 1'b1};
    vecs[4] = '{a: 8'h00, b: 8'h00, y: 8'h00, borrow: 1'b0, ovf: 1'b0};
    vecs[5] = '{a: 8'hFF, b: 8'hFF, y: 8'h00, borrow: 1'b0, ovf: 1'b0};

    // Clock/reset
    repeat (2) @(posedge CLK);
    #1;
    check("rst_y", {24'd0, Y}, 32'd0);
    check("rst_flags", {30'd0, BORROW, OVF}, 32'd0);
    check("rst_done_valid", {31'd0, DONE_VALID}, 32'd0);
    check("rst_start_ready", {31'd0, START_READY}, 32'd1);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK); #1;

    // DONE_READY high while idle must not matter
    DONE_READY = 1'b1;
    @(posedge CLK); #1;
    DONE_READY = 1'b0;
    check("idle_done_ready_ignored", {31'd0, DONE_VALID}, 32'd0);

    // Directed table
    for (int i = 0; i < 6; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].borrow, vecs[i].ovf, 1'b0, 0);

    // Backpressure with ignored start pulses
    run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0, 5);

    // Operands change every cycle during RUN
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b1, 2);

    // Async reset in the middle of RUN cycle 4
    wait_start_ready();
    START_VALID = 1'b1;
    A = 8'h55;
    B = 8'h22;
    @(posedge CLK); #1;
    START_VALID = 1'b0;
    repeat (4) @(posedge CLK);
    #2;
    check("pre_reset_running", {30'd0, DBG_STATE}, 32'd1);
    RESET_N = 1'b0;
    #1;
    check("midrst_y", {24'd0, Y}, 32'd0);
    check("midrst_flags", {30'd0, BORROW, OVF}, 32'd0);
    check("midrst_done_valid", {31'd0, DONE_VALID}, 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    check("post_rst_start_ready", {31'd0, START_READY}, 32'd1);
    repeat (W + 2) @(posedge CLK);
    #1;
    check("no_partial_result", {31'd0, DONE_VALID}, 32'd0);
    run_op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 1'b0, 0);

    // Randomized against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 8 == 0) rb = ra;
      model(ra, rb, ey, eb, eo);
      repeat ($urandom_range(0, 2)) @(posedge CLK);
      #1;
      run_op(ra, rb, ey, eb, eo, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial subtractor. Computes Y = A - B (WIDTH bits) one bit per clock by reusing a single full-adder cell with B inverted and carry-in forced to 1.
- It is the inverse-direction companion to the team's ripple ADDER cell, for area-constrained datapaths in the structural processor.
- Operands enter and results leave through valid/ready handshakes, so the block can sit between the register file and the writeback stage.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range >= 1.

Ports:
- CLK  input  1  rising-edge clock.
- RESET_N  input  1  asynchronous, active-low reset.
- START_VALID  input  1  operands A/B are valid.
- START_READY  output  1  block can accept operands (high only in IDLE).
- A  input  WIDTH  minuend, unsigned or two's complement.
- B  input  WIDTH  subtrahend.
- DONE_VALID  output  1  Y/BORROW/OVF hold a finished result.
- DONE_READY  input  1  consumer accepts the result.
- Y  output  WIDTH  difference A - B modulo 2^WIDTH.
- BORROW  output  1  1 when unsigned A < B (inverse of final carry).
- OVF  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB).

Behaviour:
- Reset: RESET_N low asynchronously forces state IDLE. It also clears Y, BORROW, OVF, DONE_VALID, shift registers, bit counter and carry to 0. START_READY = 1 while in IDLE after reset.
- Reset mid-operation: any in-flight computation is abandoned with no partial result visible, and the block resumes in IDLE.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - START_READY = 1, DONE_VALID = 0.
  - On the edge with START_VALID & START_READY: load a_sr <= A, b_sr <= B, carry <= 1, count <= 0; go to RUN.
  - START_VALID low: stay in IDLE.
- RUN (START_READY = 0, DONE_VALID = 0):
  - Each cycle: diff_bit = a_sr[0] ^ ~b_sr[0] ^ carry.
  - Next carry = majority(a_sr[0], ~b_sr[0], carry).
  - a_sr and b_sr shift right by 1; diff_bit shifts into the MSB of the result register, which is shifted right.
  - count increments.
  - On the cycle processing bit WIDTH-1, the carry-in is captured as c_msb. The final carry-out gives BORROW = ~carry_out and OVF = c_msb ^ carry_out. The FSM then goes to DONE.
- Latency: DONE_VALID rises exactly WIDTH cycles after the accepting edge. For WIDTH = 1 it rises on the next edge.
- DONE:
  - DONE_VALID = 1; Y, BORROW and OVF are stable.
  - On the edge with DONE_VALID & DONE_READY, go to IDLE; START_READY becomes 1 the following cycle. There is no same-cycle result/operand overlap.
  - DONE_READY low holds DONE indefinitely with outputs unchanged.
- Y, BORROW and OVF keep their last values in IDLE until the next accepted start. They are updated only during RUN via the shift register and are not externally valid until DONE_VALID.
- A and B are sampled only at the accepting edge; changes during RUN or DONE are ignored. START_VALID outside IDLE is ignored.
- DONE_READY outside DONE is ignored.
- Arithmetic is pure modulo 2^WIDTH; no saturation.

Test Plan:
- WIDTH = 8, A = 0x05, B = 0x03, DONE_READY = 1 -> DONE_VALID exactly 8 cycles after accept; Y = 0x02, BORROW = 0, OVF = 0.
- A = 0x03, B = 0x05 -> Y = 0xFE, BORROW = 1, OVF = 0. Then A = 0x80, B = 0x01 -> Y = 0x7F, BORROW = 0, OVF = 1. Then A = 0x7F, B = 0xFF -> Y = 0x80, BORROW = 1, OVF = 1.
- A = B = 0x00, and separately A = B = 0xFF -> Y = 0x00, BORROW = 0, OVF = 0.
- Backpressure: hold DONE_READY = 0 for 5 cycles after DONE_VALID -> Y/BORROW/OVF/DONE_VALID unchanged and START_READY = 0. Pulse START_VALID with new operands during this time -> ignored. Raise DONE_READY -> IDLE, START_READY = 1 next cycle.
- Change A/B every cycle during RUN -> result matches operands at the accept edge only.
- Assert RESET_N = 0 asynchronously mid-edge at RUN cycle 4 -> all outputs 0 immediately, START_READY = 1 after release. A new operation 0x10 - 0x01 then completes normally with Y = 0x0F.
